// File: rtl/counter64_if.sv
// Handshake bundle between the 64-bit counter controller and its neighbours.
// HI_WIDTH sets the upper-word width and must match the attached controller.
interface counter64_if #(
  parameter int HI_WIDTH = 32
);
  logic                cmd_start;
  logic                cmd_stop;
  logic                cmd_clear;
  logic [31:0]         lo_count;
  logic                lo_ovf;
  logic                snap_req;
  logic                cnt_en;
  logic                cnt_res;
  logic [HI_WIDTH-1:0] hi_count;
  logic [31:0]         snap_lo;
  logic [HI_WIDTH-1:0] snap_hi;
  logic                snap_valid;
  logic                running;
  logic                wrap_sticky;

  modport master (
    output cmd_start, cmd_stop, cmd_clear,
    output lo_count, lo_ovf, snap_req,
    input  cnt_en, cnt_res, hi_count,
    input  snap_lo, snap_hi, snap_valid,
    input  running, wrap_sticky
  );

  modport slave (
    input  cmd_start, cmd_stop, cmd_clear,
    input  lo_count, lo_ovf, snap_req,
    output cnt_en, cnt_res, hi_count,
    output snap_lo, snap_hi, snap_valid,
    output running, wrap_sticky
  );
endinterface

// File: rtl/counter64_ctrl.sv
// Start/stop/clear control, upper word and coherent snapshots for a 64-bit counter.
// Optional COUNTER64_SATURATE_EN: upper word saturates and forces HALT.
module counter64_ctrl #(
  parameter int HI_WIDTH = 32
) (
  input  logic       clk,
  input  logic       res,
  counter64_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HI_WIDTH-1:0] hi_q, hi_d;
  logic [HI_WIDTH-1:0] shi_q, shi_d;
  logic [31:0]         slo_q, slo_d;
  logic                sv_q, sv_d;
  logic                wrap_q, wrap_d;
  logic                hi_max;
  logic                start_ok;

  assign hi_max = &hi_q;

`ifdef COUNTER64_SATURATE_EN
  assign start_ok = ~wrap_q;
`else
  assign start_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    wrap_d  = wrap_q;
    slo_d   = slo_q;
    shi_d   = shi_q;
    sv_d    = bus.snap_req;

    // Adding lo_ovf covers the cycle where hi has not yet caught up
    if (bus.snap_req) begin
      slo_d = bus.lo_count;
      shi_d = hi_q + HI_WIDTH'(bus.lo_ovf);
`ifdef COUNTER64_SATURATE_EN
      if (hi_max && bus.lo_ovf) shi_d = '1;
`endif
    end

    if (bus.cmd_clear) begin
      state_d = IDLE;
      hi_d    = '0;
      wrap_d  = 1'b0;
    end else begin
      if (bus.cmd_stop) begin
        if (state_q == RUN) state_d = HALT;
      end else if (bus.cmd_start) begin
        if (state_q != RUN && start_ok) state_d = RUN;
      end
      if (bus.lo_ovf) begin
        hi_d = hi_q + HI_WIDTH'(1);
        if (hi_max) begin
          wrap_d = 1'b1;
`ifdef COUNTER64_SATURATE_EN
          hi_d    = hi_q;
          state_d = HALT;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      hi_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      sv_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      sv_q    <= sv_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.cnt_en      = (state_q == RUN);
  assign bus.running     = (state_q == RUN);
  assign bus.cnt_res     = res | bus.cmd_clear;
  assign bus.hi_count    = hi_q;
  assign bus.snap_lo     = slo_q;
  assign bus.snap_hi     = shi_q;
  assign bus.snap_valid  = sv_q;
  assign bus.wrap_sticky = wrap_q;

endmodule

// File: tb/tb_counter64_ctrl.sv
// Directed vector bench for counter64_ctrl.
// A second narrow instance exercises upper-word wrap/saturation.
module tb_counter64_ctrl;

  logic clk;
  logic res;
  int   total;
  int   bad;

  counter64_if #(.HI_WIDTH(32)) bus ();
  counter64_if #(.HI_WIDTH(3))  sb ();

  counter64_ctrl #(.HI_WIDTH(32)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  counter64_ctrl #(.HI_WIDTH(3)) dut2 (
    .clk (clk),
    .res (res),
    .bus (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        res;
    bit        st;
    bit        sp;
    bit        cl;
    bit [31:0] lo;
    bit        ovf;
    bit        sr;
    bit        e_en;
    bit        e_cres;
    bit        e_run;
    bit [31:0] e_hi;
    bit        e_wrap;
    bit        e_sv;
    bit [31:0] e_slo;
    bit [31:0] e_shi;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step2(input bit st, input bit sp, input bit cl,
                       input bit ovf, input bit sr);
    sb.cmd_start = st;
    sb.cmd_stop  = sp;
    sb.cmd_clear = cl;
    sb.lo_ovf    = ovf;
    sb.snap_req  = sr;
    sb.lo_count  = 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //          res st sp cl lo            ovf sr en cr run hi  wr sv slo           shi
    tbl[0]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0};
    tbl[1]  = '{0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 1, 0,  0, 0, 32'h0,        0};
    tbl[2]  = '{0, 0, 0, 0, 32'h1,        0, 0, 1, 0, 1, 0,  0, 0, 32'h0,        0};
    tbl[3]  = '{0, 0, 0, 0, 32'h7,        0, 1, 1, 0, 1, 0,  0, 1, 32'h7,        0};
    tbl[4]  = '{0, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 1, 0,  0, 0, 32'h7,        0};
    tbl[5]  = '{0, 0, 0, 0, 32'h0,        1, 1, 1, 0, 1, 1,  0, 1, 32'h0,        1};
    tbl[6]  = '{0, 0, 0, 0, 32'h1,        0, 1, 1, 0, 1, 1,  0, 1, 32'h1,        1};
    tbl[7]  = '{0, 0, 1, 0, 32'h2,        0, 0, 1, 0, 0, 1,  0, 0, 32'h1,        1};
    tbl[8]  = '{0, 1, 0, 0, 32'h2,        0, 0, 0, 0, 1, 1,  0, 0, 32'h1,        1};
    tbl[9]  = '{0, 1, 1, 0, 32'h3,        0, 0, 1, 0, 0, 1,  0, 0, 32'h1,        1};
    tbl[10] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 2,  0, 0, 32'h1,        1};
    tbl[11] = '{0, 1, 1, 1, 32'h20,       0, 0, 0, 1, 0, 0,  0, 0, 32'h1,        1};
    tbl[12] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 1,  0, 0, 32'h1,        1};
    tbl[13] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 2,  0, 0, 32'h1,        1};
    tbl[14] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 3,  0, 0, 32'h1,        1};
    tbl[15] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 4,  0, 0, 32'h1,        1};
    tbl[16] = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 5,  0, 0, 32'h1,        1};
    tbl[17] = '{0, 0, 0, 1, 32'h20,       0, 1, 0, 1, 0, 0,  0, 1, 32'h20,       5};
    tbl[18] = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0,  0, 0, 32'h20,       5};
    tbl[19] = '{0, 1, 0, 0, 32'h0,        0, 0, 0, 0, 1, 0,  0, 0, 32'h20,       5};
    tbl[20] = '{1, 0, 0, 0, 32'h9,        0, 1, 1, 1, 0, 0,  0, 0, 32'h0,        0};

    res           = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_stop  = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.lo_count  = 32'h0;
    bus.lo_ovf    = 1'b0;
    bus.snap_req  = 1'b0;
    sb.cmd_start  = 1'b0;
    sb.cmd_stop   = 1'b0;
    sb.cmd_clear  = 1'b0;
    sb.lo_count   = 32'h0;
    sb.lo_ovf     = 1'b0;
    sb.snap_req   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt_res", 32'(bus.cnt_res), 32'h1);
    chk("rst_cnt_en", 32'(bus.cnt_en), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_hi", bus.hi_count, 32'h0);
    chk("rst_snap_lo", bus.snap_lo, 32'h0);
    chk("rst_snap_hi", bus.snap_hi, 32'h0);
    chk("rst_snap_valid", 32'(bus.snap_valid), 32'h0);
    chk("rst_wrap", 32'(bus.wrap_sticky), 32'h0);

    for (int i = 0; i < 21; i++) begin
      res           = tbl[i].res;
      bus.cmd_start = tbl[i].st;
      bus.cmd_stop  = tbl[i].sp;
      bus.cmd_clear = tbl[i].cl;
      bus.lo_count  = tbl[i].lo;
      bus.lo_ovf    = tbl[i].ovf;
      bus.snap_req  = tbl[i].sr;
      #1;
      chk($sformatf("v%0d_cnt_en", i), 32'(bus.cnt_en), 32'(tbl[i].e_en));
      chk($sformatf("v%0d_cnt_res", i), 32'(bus.cnt_res), 32'(tbl[i].e_cres));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_running", i), 32'(bus.running), 32'(tbl[i].e_run));
      chk($sformatf("v%0d_hi", i), bus.hi_count, tbl[i].e_hi);
      chk($sformatf("v%0d_wrap", i), 32'(bus.wrap_sticky), 32'(tbl[i].e_wrap));
      chk($sformatf("v%0d_snap_valid", i), 32'(bus.snap_valid), 32'(tbl[i].e_sv));
      chk($sformatf("v%0d_snap_lo", i), bus.snap_lo, tbl[i].e_slo);
      chk($sformatf("v%0d_snap_hi", i), bus.snap_hi, tbl[i].e_shi);
    end

    res           = 1'b0;
    bus.snap_req  = 1'b0;

    // Narrow instance: drive upper word to all-ones, then overflow it
    for (int k = 0; k < 7; k++) step2(0, 0, 0, 1, 0);
    chk("w_hi_max", 32'(sb.hi_count), 32'h7);
    chk("w_wrap_pre", 32'(sb.wrap_sticky), 32'h0);
    step2(0, 0, 0, 1, 1);
    chk("w_snap_valid", 32'(sb.snap_valid), 32'h1);
    chk("w_wrap_set", 32'(sb.wrap_sticky), 32'h1);
`ifdef COUNTER64_SATURATE_EN
    chk("w_hi_hold", 32'(sb.hi_count), 32'h7);
    chk("w_snap_hi_sat", 32'(sb.snap_hi), 32'h7);
    step2(1, 0, 0, 0, 0);
    chk("w_start_ignored", 32'(sb.running), 32'h0);
`else
    chk("w_hi_wrap", 32'(sb.hi_count), 32'h0);
    chk("w_snap_hi_mod", 32'(sb.snap_hi), 32'h0);
    step2(1, 0, 0, 0, 0);
    chk("w_start_runs", 32'(sb.running), 32'h1);
`endif
    step2(0, 0, 1, 0, 0);
    chk("w_clear_wrap", 32'(sb.wrap_sticky), 32'h0);
    chk("w_clear_hi", 32'(sb.hi_count), 32'h0);
    chk("w_clear_idle", 32'(sb.running), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
